// File: rtl/dco_frac_retune.sv
// dco_frac_retune: phase-accumulator DCO with fractional wrap and wrap-synchronous retune
module dco_frac_retune #(
  parameter int bit_count = 24,
  parameter int min_value = 0,
  parameter int cnt_bits = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 mode_pulse,
  input  logic                 mode_rem,
  input  logic [bit_count-1:0] speed_var,
  input  logic [bit_count-1:0] mod,
  output logic                 signal_out,
  output logic                 wrap_pulse,
  output logic [bit_count-1:0] accum,
  output logic [cnt_bits-1:0]  wrap_count,
  output logic                 upd_pending,
  output logic                 cfg_err
);
  localparam logic [bit_count-1:0] min_v = bit_count'(min_value);
  logic [bit_count-1:0] speed_q, speed_d, mod_q, mod_d, sh_speed_q, sh_speed_d, sh_mod_q, sh_mod_d;
  logic [bit_count-1:0] accum_q, accum_d, rem;
  logic [cnt_bits-1:0]  cnt_q, cnt_d;
  logic                 pend_q, pend_d, sig_q, sig_d, wp_q, wp_d, err_q, err_d;
  logic [bit_count:0]   sum, lim;
  logic                 wrap, bad, apply;
  // next-state: one extra bit of headroom so mod = all-ones still has a reachable limit
  always_comb begin
    sum = {1'b0, accum_q} + {1'b0, speed_q};
    lim = {1'b0, mod_q} + (bit_count + 1)'(1);
    rem = sum[bit_count-1:0] - lim[bit_count-1:0];
    wrap = en && (sum >= lim);
    bad = speed_q > mod_q;
    apply = wrap && pend_q && !load;
    accum_d = !en ? accum_q : !wrap ? sum[bit_count-1:0] : (mode_rem && !bad) ? rem : min_v;
    err_d = err_q | (wrap & mode_rem & bad);
    wp_d = wrap;
    cnt_d = cnt_q + cnt_bits'(wrap);
    sig_d = !en ? sig_q : mode_pulse ? wrap : sig_q ^ wrap;
    sh_speed_d = load ? speed_var : sh_speed_q;
    sh_mod_d = load ? mod : sh_mod_q;
    pend_d = load | (pend_q & ~wrap);
    speed_d = apply ? sh_speed_q : speed_q;
    mod_d = apply ? sh_mod_q : mod_q;
  end
  // state registers; reset loads the live tuning word into both active and shadow
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q <= min_v;
      cnt_q <= '0;
      pend_q <= 1'b0;
      sig_q <= 1'b0;
      wp_q <= 1'b0;
      err_q <= 1'b0;
      speed_q <= speed_var;
      mod_q <= mod;
      sh_speed_q <= speed_var;
      sh_mod_q <= mod;
    end else begin
      accum_q <= accum_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      sig_q <= sig_d;
      wp_q <= wp_d;
      err_q <= err_d;
      speed_q <= speed_d;
      mod_q <= mod_d;
      sh_speed_q <= sh_speed_d;
      sh_mod_q <= sh_mod_d;
    end
  end
  assign accum = accum_q;
  assign wrap_count = cnt_q;
  assign upd_pending = pend_q;
  assign signal_out = sig_q;
  assign wrap_pulse = wp_q;
  assign cfg_err = err_q;
endmodule
